// File: rtl/reset_release_sequencer_if.sv
// Signal bundle between a reset_release_sequencer and its surroundings.
// The master side (board logic / testbench) drives the lock indication and
// the software request; the slave side (the sequencer) drives the reset
// bank and its status.
//
// Signalling: there is no valid/ready handshake on this bundle. pll_locked
// is a level that is sampled on every rising clk edge. soft_reset_req is a
// single-cycle pulse that acts on the edge that samples it. stage_reset,
// seq_done and seq_state are registered levels, valid on every cycle.
interface reset_release_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    logic                  pll_locked;
    logic                  soft_reset_req;
    logic [NUM_STAGES-1:0] stage_reset;
    logic                  seq_done;
    logic [1:0]            seq_state;

    modport master (
        output pll_locked,
        output soft_reset_req,
        input  stage_reset,
        input  seq_done,
        input  seq_state
    );

    modport slave (
        input  pll_locked,
        input  soft_reset_req,
        output stage_reset,
        output seq_done,
        output seq_state
    );
endinterface

// File: rtl/reset_release_sequencer.sv
// Reset release sequencer in the clk domain.
// Keeps every stage_reset bit asserted until pll_locked has been high for
// LOCK_FILTER consecutive edges and a further HOLD_CYCLES edges have passed,
// then releases the bits one by one (bit 0 first), STAGE_GAP edges apart.
// Lock loss drops back to WAIT_LOCK; a software request restarts from HOLD.
// Every output is a flop, so nothing combinational reaches the reset bank.
module reset_release_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int LOCK_FILTER = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8
) (
    input  logic                        clk,
    input  logic                        async_reset,
    reset_release_sequencer_if.slave    bus
);

    // Counter widths: just wide enough to reach PARAM-1, never below 1 bit.
    localparam int LW = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GW = (STAGE_GAP   > 1) ? $clog2(STAGE_GAP)   : 1;
    localparam int IW = (NUM_STAGES  > 1) ? $clog2(NUM_STAGES)  : 1;

    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_FILTER - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_STAGES - 1);
    localparam logic [IW-1:0] FIRST_GAP_IDX = IW'(1);

    localparam logic [NUM_STAGES-1:0] ALL_ASSERTED = {NUM_STAGES{1'b1}};
    localparam logic [NUM_STAGES-1:0] BIT0         = NUM_STAGES'(1);

    // Reject nonsensical parameterisations while elaborating.
    if (NUM_STAGES < 1 || LOCK_FILTER < 1 || HOLD_CYCLES < 1 || STAGE_GAP < 1) begin : g_param_check
        $error("reset_release_sequencer: all parameters must be >= 1");
    end

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t                state_q,    state_d;
    logic [LW-1:0]         lock_cnt_q, lock_cnt_d;
    logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
    logic [GW-1:0]         gap_cnt_q,  gap_cnt_d;
    logic [IW-1:0]         rel_idx_q,  rel_idx_d;   // next bit to release
    logic [NUM_STAGES-1:0] stage_q,    stage_d;
    logic                  done_q,     done_d;

    // State, counters and the output bank; reset forces the fully-held state.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state_q    <= WAIT_LOCK;
            lock_cnt_q <= '0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            rel_idx_q  <= '0;
            stage_q    <= ALL_ASSERTED;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            rel_idx_q  <= rel_idx_d;
            stage_q    <= stage_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic: normal progression first, aborts override it last.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        rel_idx_d  = rel_idx_q;
        stage_d    = stage_q;
        done_d     = done_q;

        case (state_q)
            WAIT_LOCK: begin
                // Any low sample restarts the filter; soft requests are moot here.
                if (bus.pll_locked) begin
                    if (lock_cnt_q == LOCK_LAST) begin
                        state_d    = HOLD;
                        lock_cnt_d = '0;
                        hold_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LW'(1);
                    end
                end else begin
                    lock_cnt_d = '0;
                end
            end

            HOLD: begin
                hold_cnt_d = hold_cnt_q + HW'(1);
                if (hold_cnt_q == HOLD_LAST) begin
                    // Hold time met: release bit 0 right away.
                    stage_d    = stage_q & ~BIT0;
                    hold_cnt_d = '0;
                    gap_cnt_d  = '0;
                    rel_idx_d  = FIRST_GAP_IDX;
                    if (NUM_STAGES == 1) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end
            end

            RELEASE: begin
                gap_cnt_d = gap_cnt_q + GW'(1);
                if (gap_cnt_q == GAP_LAST) begin
                    // Release the lowest still-asserted bit.
                    stage_d   = stage_q & ~(BIT0 << rel_idx_q);
                    gap_cnt_d = '0;
                    if (rel_idx_q == LAST_IDX) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        rel_idx_d = rel_idx_q + IW'(1);
                    end
                end
            end

            DONE: begin
                // Everything released; outputs stay put until an abort.
            end

            default: begin
                state_d = WAIT_LOCK;
            end
        endcase

        // Aborts outside WAIT_LOCK; lock loss outranks a software request.
        if (state_q != WAIT_LOCK) begin
            if (!bus.pll_locked) begin
                state_d    = WAIT_LOCK;
                lock_cnt_d = '0;
                hold_cnt_d = '0;
                gap_cnt_d  = '0;
                rel_idx_d  = '0;
                stage_d    = ALL_ASSERTED;
                done_d     = 1'b0;
            end else if (bus.soft_reset_req) begin
                // Lock is still good, so skip the filter and re-run the hold.
                state_d    = HOLD;
                hold_cnt_d = '0;
                gap_cnt_d  = '0;
                rel_idx_d  = '0;
                stage_d    = ALL_ASSERTED;
                done_d     = 1'b0;
            end
        end
    end

    assign bus.stage_reset = stage_q;
    assign bus.seq_done    = done_q;
    assign bus.seq_state   = state_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Bench for reset_release_sequencer: a default 4-stage instance and a
// 1-stage corner instance share clk and reset. Scenarios push the expected
// output transitions (edge index plus output values) into a queue; a
// monitor per instance pops an entry whenever that instance's outputs change.
module tb_reset_release_sequencer;

    localparam int W = 39;  // {edge[31:0], stage_reset[3:0], seq_done, seq_state[1:0]}

    logic clk;
    logic rst;

    reset_release_sequencer_if #(.NUM_STAGES(4)) bus4 ();
    reset_release_sequencer_if #(.NUM_STAGES(1)) bus1 ();

    reset_release_sequencer #(
        .NUM_STAGES (4),
        .LOCK_FILTER(4),
        .HOLD_CYCLES(16),
        .STAGE_GAP  (8)
    ) dut4 (
        .clk        (clk),
        .async_reset(rst),
        .bus        (bus4)
    );

    reset_release_sequencer #(
        .NUM_STAGES (1),
        .LOCK_FILTER(1),
        .HOLD_CYCLES(1),
        .STAGE_GAP  (8)
    ) dut1 (
        .clk        (clk),
        .async_reset(rst),
        .bus        (bus1)
    );

    // ---------------- clock / edge index ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Index of the most recent rising edge since reset release (-1 in reset).
    int edge_idx;
    always @(posedge clk or posedge rst) begin
        if (rst) edge_idx = -1;
        else     edge_idx = edge_idx + 1;
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp4_q[$];
    logic [W-1:0] exp1_q[$];
    int n_checks;
    int n_fail;
    logic mon4_en;
    logic mon1_en;

    function automatic logic [W-1:0] rec(input int e, input logic [3:0] sr,
                                         input logic d, input logic [1:0] s);
        return {32'(e), sr, d, s};
    endfunction

    task automatic check_rec(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got edge=%0d sr=%b done=%b st=%0d, required edge=%0d sr=%b done=%b st=%0d",
                     name, $signed(act[38:7]), act[6:3], act[2], act[1:0],
                     $signed(req[38:7]), req[6:3], req[2], req[1:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // ---------------- monitors ----------------
    logic [6:0] prev4, cur4;
    always @(negedge clk) begin
        cur4 = {bus4.stage_reset, bus4.seq_done, bus4.seq_state};
        if (mon4_en && cur4 != prev4) begin
            if (exp4_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut4_unexpected_event: got edge=%0d sr=%b done=%b st=%0d, required no change",
                         edge_idx, cur4[6:3], cur4[2], cur4[1:0]);
            end else begin
                check_rec("dut4_event", {32'(edge_idx), cur4}, exp4_q.pop_front());
            end
        end
        prev4 = cur4;
    end

    logic [6:0] prev1, cur1;
    always @(negedge clk) begin
        cur1 = {3'b000, bus1.stage_reset, bus1.seq_done, bus1.seq_state};
        if (mon1_en && cur1 != prev1) begin
            if (exp1_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut1_unexpected_event: got edge=%0d sr=%b done=%b st=%0d, required no change",
                         edge_idx, cur1[6:3], cur1[2], cur1[1:0]);
            end else begin
                check_rec("dut1_event", {32'(edge_idx), cur1}, exp1_q.pop_front());
            end
        end
        prev1 = cur1;
    end

    // ---------------- driver tasks ----------------
    // Return at the falling edge following rising edge n; inputs set here
    // are sampled by edge n+1.
    task automatic go_to(input int n);
        while (edge_idx < n) @(negedge clk);
    endtask

    task automatic start_scn(input logic pll_init);
        mon4_en = 1'b0;
        mon1_en = 1'b0;
        rst = 1'b1;
        bus4.pll_locked     = pll_init;
        bus4.soft_reset_req = 1'b0;
        bus1.pll_locked     = 1'b1;
        bus1.soft_reset_req = 1'b0;
        exp4_q.delete();
        exp1_q.delete();
        @(negedge clk);
        #1;
        check_rec("reset_state4",
                  {32'(edge_idx), bus4.stage_reset, bus4.seq_done, bus4.seq_state},
                  rec(-1, 4'b1111, 1'b0, 2'd0));
        check_rec("reset_state1",
                  {32'(edge_idx), 3'b000, bus1.stage_reset, bus1.seq_done, bus1.seq_state},
                  rec(-1, 4'b0001, 1'b0, 2'd0));
        @(negedge clk);
        rst = 1'b0;
        mon4_en = 1'b1;
    endtask

    task automatic end_scn(input string name);
        check_int({name, "_drained4"}, exp4_q.size(), 0);
        mon4_en = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        mon4_en  = 1'b0;
        mon1_en  = 1'b0;
        rst      = 1'b1;
        bus4.pll_locked     = 1'b0;
        bus4.soft_reset_req = 1'b0;
        bus1.pll_locked     = 1'b0;
        bus1.soft_reset_req = 1'b0;

        // Power-up with defaults, then a soft request while DONE.
        // The 1-stage corner instance is checked alongside.
        start_scn(1'b1);
        mon1_en = 1'b1;
        exp1_q.push_back(rec(0, 4'b0001, 1'b0, 2'd1));
        exp1_q.push_back(rec(1, 4'b0000, 1'b1, 2'd3));
        exp4_q.push_back(rec(3,  4'b1111, 1'b0, 2'd1));
        exp4_q.push_back(rec(19, 4'b1110, 1'b0, 2'd2));
        exp4_q.push_back(rec(27, 4'b1100, 1'b0, 2'd2));
        exp4_q.push_back(rec(35, 4'b1000, 1'b0, 2'd2));
        exp4_q.push_back(rec(43, 4'b0000, 1'b1, 2'd3));
        exp4_q.push_back(rec(60, 4'b1111, 1'b0, 2'd1));
        exp4_q.push_back(rec(76, 4'b1110, 1'b0, 2'd2));
        exp4_q.push_back(rec(84, 4'b1100, 1'b0, 2'd2));
        exp4_q.push_back(rec(92, 4'b1000, 1'b0, 2'd2));
        exp4_q.push_back(rec(100, 4'b0000, 1'b1, 2'd3));
        go_to(59);
        bus4.soft_reset_req = 1'b1;
        go_to(60);
        bus4.soft_reset_req = 1'b0;
        go_to(105);
        check_int("powerup_drained1", exp1_q.size(), 0);
        mon1_en = 1'b0;
        end_scn("powerup");

        // Lock glitch during filtering: low sample at edge 3.
        start_scn(1'b1);
        exp4_q.push_back(rec(7,  4'b1111, 1'b0, 2'd1));
        exp4_q.push_back(rec(23, 4'b1110, 1'b0, 2'd2));
        go_to(2);
        bus4.pll_locked = 1'b0;
        go_to(3);
        bus4.pll_locked = 1'b1;
        go_to(28);
        end_scn("glitch");

        // Lock loss in RELEASE at edge 30, restored at 31; then async reset
        // mid-release with no clock edge.
        start_scn(1'b1);
        exp4_q.push_back(rec(3,  4'b1111, 1'b0, 2'd1));
        exp4_q.push_back(rec(19, 4'b1110, 1'b0, 2'd2));
        exp4_q.push_back(rec(27, 4'b1100, 1'b0, 2'd2));
        exp4_q.push_back(rec(30, 4'b1111, 1'b0, 2'd0));
        exp4_q.push_back(rec(34, 4'b1111, 1'b0, 2'd1));
        exp4_q.push_back(rec(50, 4'b1110, 1'b0, 2'd2));
        go_to(29);
        bus4.pll_locked = 1'b0;
        go_to(30);
        bus4.pll_locked = 1'b1;
        go_to(52);
        end_scn("lockloss");
        #1 rst = 1'b1;
        #1;
        check_rec("async_reset_mid",
                  {32'(edge_idx), bus4.stage_reset, bus4.seq_done, bus4.seq_state},
                  rec(-1, 4'b1111, 1'b0, 2'd0));

        // Soft request and lock loss on the same edge in RELEASE: the lock
        // filter has to run again before HOLD.
        start_scn(1'b1);
        exp4_q.push_back(rec(3,  4'b1111, 1'b0, 2'd1));
        exp4_q.push_back(rec(19, 4'b1110, 1'b0, 2'd2));
        exp4_q.push_back(rec(27, 4'b1100, 1'b0, 2'd2));
        exp4_q.push_back(rec(29, 4'b1111, 1'b0, 2'd0));
        exp4_q.push_back(rec(33, 4'b1111, 1'b0, 2'd1));
        go_to(28);
        bus4.soft_reset_req = 1'b1;
        bus4.pll_locked     = 1'b0;
        go_to(29);
        bus4.soft_reset_req = 1'b0;
        bus4.pll_locked     = 1'b1;
        go_to(36);
        end_scn("simultaneous");

        // Soft request ignored in WAIT_LOCK (edge 1); in HOLD (edge 10) it
        // restarts the hold count so bit 0 falls at edge 26.
        start_scn(1'b1);
        exp4_q.push_back(rec(3,  4'b1111, 1'b0, 2'd1));
        exp4_q.push_back(rec(26, 4'b1110, 1'b0, 2'd2));
        go_to(0);
        bus4.soft_reset_req = 1'b1;
        go_to(1);
        bus4.soft_reset_req = 1'b0;
        go_to(9);
        bus4.soft_reset_req = 1'b1;
        go_to(10);
        bus4.soft_reset_req = 1'b0;
        go_to(30);
        end_scn("soft_hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
